// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Data-hazard unit beside the decode stage. Tracks in-flight
//               destination registers from EX (entry 0) to WB (entry
//               PIPE_DEPTH-1), stalls decode when an operand is not yet
//               available, optionally produces forwarding selects, and keeps
//               a saturating stall-cycle counter.
// Build macro : HAZARD_FORWARD_EN - when defined, only load-use stalls and
//               FWD_SRCn_SEL select the youngest matching entry (index + 1);
//               when undefined, any pending match stalls and FWD_* read 0.
// Ports       : CLK, RESET (sync, active-high)
//               DE_VALID, DE_SRC1, DE_SRC2, DE_RD, DE_TYPE, DE_IS_LOAD - decode
//               FLUSH            - squash decode and all tracked stages
//               STALL_PROCESSOR  - hold PC and IF/DE, bubble into EX
//               FWD_SRC1_SEL/FWD_SRC2_SEL - 0 = register file, k = entry k-1
//               STALL_COUNT      - saturating count of stalled cycles
// Type codes  : R=0 I=1 S=2 B=3 U=4 J=5
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int PIPE_DEPTH = 3,
    parameter int REG_AW     = 5,
    parameter int TYPE_W     = 3,
    parameter int SEL_W      = 2,
    parameter int CNT_W      = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              DE_VALID,
    input  logic [REG_AW-1:0] DE_SRC1,
    input  logic [REG_AW-1:0] DE_SRC2,
    input  logic [REG_AW-1:0] DE_RD,
    input  logic [TYPE_W-1:0] DE_TYPE,
    input  logic              DE_IS_LOAD,
    input  logic              FLUSH,
    output logic              STALL_PROCESSOR,
    output logic [SEL_W-1:0]  FWD_SRC1_SEL,
    output logic [SEL_W-1:0]  FWD_SRC2_SEL,
    output logic [CNT_W-1:0]  STALL_COUNT
);

    localparam logic [TYPE_W-1:0] c_TYPE_R = TYPE_W'(0);
    localparam logic [TYPE_W-1:0] c_TYPE_I = TYPE_W'(1);
    localparam logic [TYPE_W-1:0] c_TYPE_S = TYPE_W'(2);
    localparam logic [TYPE_W-1:0] c_TYPE_B = TYPE_W'(3);
    localparam logic [TYPE_W-1:0] c_TYPE_U = TYPE_W'(4);
    localparam logic [TYPE_W-1:0] c_TYPE_J = TYPE_W'(5);

    // Pipe state: entry 0 = EX ... entry PIPE_DEPTH-1 = WB
    logic [PIPE_DEPTH-1:0] r_valid;
    logic [PIPE_DEPTH-1:0] r_load;
    logic [REG_AW-1:0]     r_rd [PIPE_DEPTH];
    logic [CNT_W-1:0]      r_count;

    logic                  w_use1;
    logic                  w_use2;
    logic                  w_writes;
    logic [PIPE_DEPTH-1:0] w_m1;
    logic [PIPE_DEPTH-1:0] w_m2;
    logic                  w_stall;
    logic                  w_issue;

    // Operand usage and destination write by instruction type
    assign w_use1   = (DE_TYPE == c_TYPE_R) || (DE_TYPE == c_TYPE_I) ||
                      (DE_TYPE == c_TYPE_S) || (DE_TYPE == c_TYPE_B);
    assign w_use2   = (DE_TYPE == c_TYPE_R) || (DE_TYPE == c_TYPE_S) ||
                      (DE_TYPE == c_TYPE_B);
    assign w_writes = (DE_TYPE == c_TYPE_R) || (DE_TYPE == c_TYPE_I) ||
                      (DE_TYPE == c_TYPE_U) || (DE_TYPE == c_TYPE_J);

    generate
        for (genvar i = 0; i < PIPE_DEPTH; i++) begin : g_match
            assign w_m1[i] = w_use1 && r_valid[i] && (r_rd[i] == DE_SRC1) &&
                             (DE_SRC1 != '0);
            assign w_m2[i] = w_use2 && r_valid[i] && (r_rd[i] == DE_SRC2) &&
                             (DE_SRC2 != '0);
        end
    endgenerate

`ifdef HAZARD_FORWARD_EN
    logic [SEL_W-1:0] w_idx1;
    logic [SEL_W-1:0] w_idx2;

    // Scan oldest to youngest so the lowest matching index is left standing
    always_comb begin
        w_idx1 = '0;
        w_idx2 = '0;
        for (int i = PIPE_DEPTH - 1; i >= 0; i--) begin
            if (w_m1[i]) w_idx1 = SEL_W'(i);
            if (w_m2[i]) w_idx2 = SEL_W'(i);
        end
    end

    // A match at entry 0 is by definition the youngest; load data is not
    // ready until the next stage, so that is the only unforwardable case.
    assign w_stall = DE_VALID && !FLUSH &&
                     ((w_m1[0] && r_load[0]) || (w_m2[0] && r_load[0]));

    assign FWD_SRC1_SEL = (FLUSH || !(|w_m1)) ? '0 : w_idx1 + SEL_W'(1);
    assign FWD_SRC2_SEL = (FLUSH || !(|w_m2)) ? '0 : w_idx2 + SEL_W'(1);
`else
    logic w_unused_load;

    // Without forwarding the register file is the only source, and it has no
    // write-through, so any pending writer (including WB) blocks decode.
    assign w_stall       = DE_VALID && !FLUSH && ((|w_m1) || (|w_m2));
    assign FWD_SRC1_SEL  = '0;
    assign FWD_SRC2_SEL  = '0;
    assign w_unused_load = |r_load;
`endif

    assign w_issue         = DE_VALID && !w_stall && !FLUSH;
    assign STALL_PROCESSOR = w_stall;
    assign STALL_COUNT     = r_count;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_valid <= '0;
            r_load  <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) r_rd[i] <= '0;
        end else if (FLUSH) begin
            r_valid <= '0;
            r_load  <= '0;
        end else begin
            for (int i = PIPE_DEPTH - 1; i > 0; i--) begin
                r_valid[i] <= r_valid[i-1];
                r_load[i]  <= r_load[i-1];
                r_rd[i]    <= r_rd[i-1];
            end
            // Stores and branches enter as bubbles: they produce no rd
            r_valid[0] <= w_issue && w_writes;
            r_load[0]  <= w_issue && DE_IS_LOAD;
            r_rd[0]    <= DE_RD;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_count <= '0;
        end else if (w_stall && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Scoreboard bench for hazard_scoreboard. The stimulus process
//               keeps a list of issued instructions with their issue cycle,
//               derives each one's pipe position from its age, and queues the
//               expected outputs; a monitor on the falling edge pops and
//               compares. Follows HAZARD_FORWARD_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    localparam int PD = 3;
    localparam int AW = 5;
    localparam int TW = 3;
    localparam int SW = 2;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    localparam int T_R = 0, T_I = 1, T_S = 2, T_B = 3, T_U = 4, T_J = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          de_valid;
    logic [AW-1:0] de_src1, de_src2, de_rd;
    logic [TW-1:0] de_type;
    logic          de_is_load;
    logic          flush;
    logic          stall_out;
    logic [SW-1:0] sel1, sel2;
    logic [CW-1:0] cnt;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .PIPE_DEPTH(PD), .REG_AW(AW), .TYPE_W(TW), .SEL_W(SW), .CNT_W(CW)
    ) dut (
        .CLK(clk), .RESET(rst), .DE_VALID(de_valid),
        .DE_SRC1(de_src1), .DE_SRC2(de_src2), .DE_RD(de_rd),
        .DE_TYPE(de_type), .DE_IS_LOAD(de_is_load), .FLUSH(flush),
        .STALL_PROCESSOR(stall_out), .FWD_SRC1_SEL(sel1),
        .FWD_SRC2_SEL(sel2), .STALL_COUNT(cnt)
    );

    typedef struct {
        int rd;
        bit ld;
        bit wr;
        int cyc;
    } inst_t;

    typedef struct {
        bit stall;
        int s1;
        int s2;
        int cnt;
        bit chk_sel;
    } exp_t;

    inst_t inflight[$];
    exp_t  exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    now      = 0;
    int    mcount   = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Youngest in-flight writer of src, by age since issue
    task automatic youngest(input int src, input bit used,
                            output int best, output bit ld);
        best = PD;
        ld   = 1'b0;
        foreach (inflight[k]) begin
            int age;
            age = now - inflight[k].cyc - 1;
            if (used && src != 0 && inflight[k].wr && inflight[k].rd == src &&
                age < best) begin
                best = age;
                ld   = inflight[k].ld;
            end
        end
    endtask

    task automatic step(input bit v, input int s1, input int s2, input int rd,
                        input int ty, input bit ld, input bit fl, input bit r,
                        output bit issued);
        exp_t e;
        bit   u1, u2, wr, l1, l2, st1, st2;
        int   b1, b2;
        de_valid   = v;
        de_src1    = AW'(s1);
        de_src2    = AW'(s2);
        de_rd      = AW'(rd);
        de_type    = TW'(ty);
        de_is_load = ld;
        flush      = fl;
        rst        = r;
        u1 = (ty == T_R) || (ty == T_I) || (ty == T_S) || (ty == T_B);
        u2 = (ty == T_R) || (ty == T_S) || (ty == T_B);
        wr = (ty == T_R) || (ty == T_I) || (ty == T_U) || (ty == T_J);
        youngest(s1, u1, b1, l1);
        youngest(s2, u2, b2, l2);
`ifdef HAZARD_FORWARD_EN
        st1 = (b1 == 0) && l1;
        st2 = (b2 == 0) && l2;
`else
        st1 = (b1 < PD);
        st2 = (b2 < PD);
`endif
        e.stall = v && !fl && (st1 || st2);
        issued  = v && !e.stall && !fl;
        e.cnt   = mcount;
`ifdef HAZARD_FORWARD_EN
        e.s1      = (fl || b1 >= PD) ? 0 : b1 + 1;
        e.s2      = (fl || b2 >= PD) ? 0 : b2 + 1;
        e.chk_sel = issued || fl;
`else
        e.s1      = 0;
        e.s2      = 0;
        e.chk_sel = 1'b1;
`endif
        exp_q.push_back(e);
        @(posedge clk);
        if (r) begin
            inflight.delete();
            mcount = 0;
        end else begin
            if (e.stall && mcount != CMAX) mcount++;
            if (fl) inflight.delete();
            else if (issued) inflight.push_back('{rd: rd, ld: ld, wr: wr, cyc: now});
        end
        now++;
        while (inflight.size() != 0 && (now - inflight[0].cyc - 1) >= PD)
            void'(inflight.pop_front());
        #1;
    endtask

    // Present one instruction and hold it until it issues (bounded)
    task automatic hold(input int s1, input int s2, input int rd, input int ty,
                        input bit ld);
        bit iss;
        for (int k = 0; k < 8; k++) begin
            step(1, s1, s2, rd, ty, ld, 0, 0, iss);
            if (iss) break;
        end
    endtask

    task automatic idle(input int n);
        bit iss;
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, T_R, 0, 0, 0, iss);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("stall", int'(stall_out), int'(e.stall));
            check("stall_count", int'(cnt), e.cnt);
            if (e.chk_sel) begin
                check("fwd_src1_sel", int'(sel1), e.s1);
                check("fwd_src2_sel", int'(sel2), e.s2);
            end
        end
    end

    initial begin
        bit iss;
        rst = 1'b1; de_valid = 1'b0; de_src1 = '0; de_src2 = '0; de_rd = '0;
        de_type = '0; de_is_load = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset sampled with random inputs, then pipe must read empty
        step(1, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 5), 1'($urandom), 0, 1, iss);
        idle(1);

        // add x5,x1,x2 ; sub x6,x5,x5 ; addi x7,x5
        hold(1, 2, 5, T_R, 0);
        hold(5, 5, 6, T_R, 0);
        hold(5, 0, 7, T_I, 0);
        idle(PD);

        // lw x7 ; add x8,x7,x0
        hold(1, 0, 7, T_I, 1);
        hold(7, 0, 8, T_R, 0);
        idle(PD);

        // add x5 ; add x9,x5,x0
        hold(1, 2, 5, T_R, 0);
        hold(5, 0, 9, T_R, 0);
        idle(PD);

        // x0 destination never blocks
        hold(1, 2, 0, T_R, 0);
        hold(0, 0, 3, T_R, 0);
        // store in pipe never matches
        hold(1, 2, 5, T_S, 0);
        hold(5, 5, 3, T_R, 0);
        idle(PD);
        // U-type operand fields are ignored
        hold(1, 2, 5, T_R, 0);
        hold(5, 5, 4, T_U, 0);
        idle(PD);

        // Flush while stalled, then the instruction re-presents
        hold(1, 0, 7, T_I, 1);
        step(1, 7, 0, 8, T_R, 0, 1, 0, iss);
        hold(7, 0, 8, T_R, 0);
        idle(PD);

        // Drive the stall counter into saturation
        for (int k = 0; k < 20; k++) begin
            hold(1, 0, 7, T_I, 1);
            hold(7, 7, 8, T_R, 0);
        end
        idle(2);

        // Reset mid-stall
        hold(1, 0, 7, T_I, 1);
        step(1, 7, 0, 8, T_R, 0, 0, 1, iss);
        hold(7, 0, 8, T_R, 0);

        // Randomised traffic over a small register set to provoke hazards
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 2) == 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0, iss);
        end

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL monitor_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
